// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage.
// Region codes and source encodings are reused by data-memory decode.
package fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h4000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  localparam logic [3:0] BIOS_REGION = 4'b0100;
  localparam logic [3:0] IMEM_REGION = 4'b0001;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_BIOS = 2'b01;
  localparam logic [1:0] SRC_IMEM = 2'b10;

  localparam logic [1:0] ST_RESET = 2'b00;
  localparam logic [1:0] ST_BOOT  = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;

  // Map the top address nibble onto a memory source.
  function automatic logic [1:0] region_src(
    input logic [3:0] region
  );
    logic [1:0] s;
    s = SRC_NONE;
    if (region == BIOS_REGION) s = SRC_BIOS;
    else if (region == IMEM_REGION) s = SRC_IMEM;
    return s;
  endfunction

endpackage

// File: rtl/fetch_unit_region_decode.sv
// Byte address to memory source and per-port word addresses.
// Purely combinational; shared with the data-memory decode.
module fetch_region_decode
  import fetch_unit_pkg::*;
#(
  parameter int BIOS_AWIDTH = 12,
  parameter int IMEM_AWIDTH = 14
) (
  input  logic [31:0]            addr,
  output logic [1:0]             src,
  output logic [BIOS_AWIDTH-1:0] bios_waddr,
  output logic [IMEM_AWIDTH-1:0] imem_waddr
);

  logic unused_addr;

  // Region select and word-address extraction.
  always_comb begin
    src        = region_src(addr[31:28]);
    bios_waddr = addr[BIOS_AWIDTH+1:2];
    imem_waddr = addr[IMEM_AWIDTH+1:2];
  end

  assign unused_addr = ^addr;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, next-PC select, BIOS/IMEM read ports.
// Delivers an aligned {pc, inst, valid} triple to ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int          BIOS_AWIDTH = 12,
  parameter int          IMEM_AWIDTH = 14,
  parameter logic [31:0] NOP_INST    = DEF_NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_pc_en,
  input  logic                   ctrl_imem_en,
  input  logic                   ctrl_pc_src,
  input  logic [31:0]            pc_target,
  output logic [BIOS_AWIDTH-1:0] bios_addr,
  output logic                   bios_en,
  input  logic [31:0]            bios_dout,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  output logic                   imem_en,
  input  logic [31:0]            imem_dout,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic                   if_valid
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  src_q, src_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  cur_state;

  logic [31:0] pc_next;
  logic [31:0] fetch_addr;
  logic        pc_load;
  logic        rd_en;
  logic        kill;
  logic [1:0]  sel_src;
  logic [1:0]  out_src;

  logic [BIOS_AWIDTH-1:0] bios_waddr;
  logic [IMEM_AWIDTH-1:0] imem_waddr;

  logic unused_tgt;
  assign unused_tgt = ^pc_target[1:0];

  // The cycle rst drops is BOOT; later cycles are RUN.
  always_comb begin
    if (rst) begin
      cur_state = ST_RESET;
    end else if (state_q == ST_RESET) begin
      cur_state = ST_BOOT;
    end else begin
      cur_state = state_q;
    end
    state_d = ST_RUN;
  end

  // Next PC and the address presented to memory.
  always_comb begin
    if (ctrl_pc_src) begin
      pc_next = {pc_target[31:2], 2'b00};
    end else begin
      pc_next = pc_q + 32'd4;
    end
    // Redirect wins over a stall.
    pc_load = ctrl_pc_en || ctrl_pc_src;
    if (rst) begin
      fetch_addr = RESET_PC;
    end else if (pc_load) begin
      fetch_addr = pc_next;
    end else begin
      fetch_addr = pc_q;
    end
  end

  fetch_region_decode #(
    .BIOS_AWIDTH(BIOS_AWIDTH),
    .IMEM_AWIDTH(IMEM_AWIDTH)
  ) u_dec (
    .addr      (fetch_addr),
    .src       (sel_src),
    .bios_waddr(bios_waddr),
    .imem_waddr(imem_waddr)
  );

  // Drive only the selected port; reset primes the boot word.
  always_comb begin
    rd_en     = ctrl_imem_en || rst;
    bios_en   = rd_en && (sel_src == SRC_BIOS);
    imem_en   = rd_en && (sel_src == SRC_IMEM);
    bios_addr = bios_waddr;
    imem_addr = imem_waddr;
  end

  // BOOT reads the word primed during reset from BIOS.
  always_comb begin
    if (cur_state == ST_BOOT) begin
      out_src = SRC_BIOS;
    end else begin
      out_src = src_q;
    end
  end

  // PC and source advance together; both hold on stall.
  always_comb begin
    if (pc_load) begin
      pc_d  = pc_next;
      src_d = sel_src;
    end else begin
      pc_d  = pc_q;
      src_d = out_src;
    end
  end

  // Output mux; wrong-path and reset cycles become a bubble.
  always_comb begin
    kill    = rst || ctrl_pc_src;
    if_pc   = rst ? RESET_PC : pc_q;
    if (kill) begin
      if_inst = NOP_INST;
    end else if (out_src == SRC_BIOS) begin
      if_inst = bios_dout;
    end else if (out_src == SRC_IMEM) begin
      if_inst = imem_dout;
    end else begin
      if_inst = NOP_INST;
    end
    if_valid = !kill && (out_src != SRC_NONE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      src_q   <= SRC_NONE;
      state_q <= ST_RESET;
    end else begin
      pc_q    <= pc_d;
      src_q   <= src_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Synchronous BIOS/IMEM models with read-enable hold.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pce;
  logic        ime;
  logic        psrc;
  logic [31:0] tgt;
  logic [11:0] bios_addr;
  logic        bios_en;
  logic [31:0] bios_dout;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_pc_en  (pce),
    .ctrl_imem_en(ime),
    .ctrl_pc_src (psrc),
    .pc_target   (tgt),
    .bios_addr   (bios_addr),
    .bios_en     (bios_en),
    .bios_dout   (bios_dout),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_dout   (imem_dout),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bw(input logic [11:0] a);
    return {8'hB1, 12'h000, a};
  endfunction

  function automatic logic [31:0] iw(input logic [13:0] a);
    return {8'h1E, 10'h000, a};
  endfunction

  always @(posedge clk) begin
    if (bios_en) bios_dout <= bw(bios_addr);
    if (imem_en) imem_dout <= iw(imem_addr);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic        r,
    input logic        pe,
    input logic        ie,
    input logic        ps,
    input logic [31:0] t
  );
    @(negedge clk);
    rst  = r;
    pce  = pe;
    ime  = ie;
    psrc = ps;
    tgt  = t;
    #1;
    chk("stall_and_redirect", {31'd0, psrc && !pce}, 32'd0);
  endtask

  task automatic run_chk(
    input string       tag,
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_inst"}, if_inst, inst);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
  endtask

  task automatic boot_seq(input string tag);
    step(0, 1, 1, 0, 0);
    run_chk({tag, "_boot"}, RPC, bw(12'd0));
    chk({tag, "_boot_baddr"}, {20'd0, bios_addr}, 32'd1);
    step(0, 1, 1, 0, 0);
    run_chk({tag, "_run1"}, RPC + 32'd4, bw(12'd1));
  endtask

  initial begin
    rst  = 1'b1;
    pce  = 1'b1;
    ime  = 1'b1;
    psrc = 1'b0;
    tgt  = '0;

    repeat (3) step(1, 1, 1, 0, 0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_pc", if_pc, RPC);
    chk("rst_bios_en", {31'd0, bios_en}, 32'd1);
    chk("rst_bios_addr", {20'd0, bios_addr}, 32'd0);
    chk("rst_imem_en", {31'd0, imem_en}, 32'd0);

    boot_seq("b0");
    for (int k = 2; k < 4; k++) begin
      step(0, 1, 1, 0, 0);
      run_chk("line", RPC + 32'(4 * k), bw(12'(k)));
    end

    step(0, 0, 0, 0, 0);
    run_chk("stall1", RPC + 32'h10, bw(12'd4));
    chk("stall1_bios_en", {31'd0, bios_en}, 32'd0);
    step(0, 0, 0, 0, 0);
    run_chk("stall2", RPC + 32'h10, bw(12'd4));
    chk("stall2_bios_en", {31'd0, bios_en}, 32'd0);
    step(0, 1, 1, 0, 0);
    run_chk("stall3", RPC + 32'h10, bw(12'd4));
    chk("stall3_baddr", {20'd0, bios_addr}, 32'd5);
    for (int k = 5; k < 8; k++) begin
      step(0, 1, 1, 0, 0);
      run_chk("resume", RPC + 32'(4 * k), bw(12'(k)));
    end

    step(0, 1, 1, 1, 32'h1000_0020);
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_inst", if_inst, NOP);
    chk("redir_imem_en", {31'd0, imem_en}, 32'd1);
    chk("redir_imem_addr", {18'd0, imem_addr}, 32'd8);
    chk("redir_bios_en", {31'd0, bios_en}, 32'd0);
    step(0, 1, 1, 0, 0);
    run_chk("imem", 32'h1000_0020, iw(14'd8));
    chk("imem_next_addr", {18'd0, imem_addr}, 32'd9);
    chk("imem_bios_en", {31'd0, bios_en}, 32'd0);

    step(0, 1, 1, 1, 32'h1000_0023);
    chk("misal_addr", {18'd0, imem_addr}, 32'd8);
    step(0, 1, 1, 0, 0);
    run_chk("misal", 32'h1000_0020, iw(14'd8));

    step(0, 1, 1, 1, 32'h2000_0000);
    chk("unm_bios_en", {31'd0, bios_en}, 32'd0);
    chk("unm_imem_en", {31'd0, imem_en}, 32'd0);
    step(0, 1, 1, 0, 0);
    chk("unm_pc", if_pc, 32'h2000_0000);
    chk("unm_valid", {31'd0, if_valid}, 32'd0);
    chk("unm_inst", if_inst, NOP);
    chk("unm_en", {30'd0, bios_en, imem_en}, 32'd0);

    step(1, 0, 0, 0, 0);
    chk("rs_valid", {31'd0, if_valid}, 32'd0);
    chk("rs_bios_en", {31'd0, bios_en}, 32'd1);
    step(1, 0, 0, 0, 0);
    chk("rs_pc", if_pc, RPC);
    chk("rs_valid2", {31'd0, if_valid}, 32'd0);
    chk("rs_inst", if_inst, NOP);
    boot_seq("b1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the 3-stage RISC-V core.
- Holds the PC and computes the next PC (sequential or redirect target).
- Drives the synchronous BIOS and IMEM read ports and delivers an aligned {pc, inst, valid} triple to the ID stage.
- Consumes the hazard unit's stall controls (ctrl_pc_en, ctrl_imem_en) and the EX-stage redirect (ctrl_pc_src, pc_target). Injects a NOP bubble on redirect and after reset.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset; BIOS region.
- BIOS_AWIDTH, 12, BIOS word-address width.
- IMEM_AWIDTH, 14, IMEM word-address width.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ctrl_pc_en  in  1  hazard unit: 1 = PC may advance; 0 = stall
- ctrl_imem_en  in  1  hazard unit: read enable for BIOS/IMEM this cycle
- ctrl_pc_src  in  1  EX stage: 1 = redirect to pc_target
- pc_target  in  32  branch/jump target from EX
- bios_addr  out  BIOS_AWIDTH  BIOS read word address
- bios_en  out  1  BIOS read enable
- bios_dout  in  32  BIOS read data, valid one cycle after the address
- imem_addr  out  IMEM_AWIDTH  IMEM read word address
- imem_en  out  1  IMEM read enable
- imem_dout  in  32  IMEM read data, valid one cycle after the address
- if_pc  out  32  PC of if_inst
- if_inst  out  32  instruction to ID
- if_valid  out  1  if_inst is a real fetched instruction

Behaviour:
- Registers:
  - pc_q: PC of the word whose data returns this cycle.
  - src_q[1:0]: source latched with the address; 01 = BIOS, 10 = IMEM, 00 = none.
  - state_q.
- States:
  - RESET: while rst = 1.
  - BOOT: first cycle after rst falls.
  - RUN: all later cycles.
- Reset (rst = 1):
  - pc_q <= RESET_PC; src_q <= 00; state_q <= RESET.
  - bios_en = 1, bios_addr = RESET_PC[BIOS_AWIDTH+1:2], so the first word is ready at BOOT.
  - Outputs: if_valid = 0, if_inst = NOP_INST, if_pc = RESET_PC.
- RESET -> BOOT on rst = 0:
  - BOOT outputs the RESET_PC word with if_valid = 1.
  - pc_next = RESET_PC + 4.
  - BOOT -> RUN unconditionally.
  - rst reasserted in any state returns to RESET the same cycle (synchronous).
- Next PC:
  - pc_next = ctrl_pc_src ? {pc_target[31:2], 2'b00} : pc_q + 4.
  - Wrap-around modulo 2^32; target low bits are forced to 0.
- Fetch address:
  - fetch_addr = ctrl_pc_en ? pc_next : pc_q.
  - Region select on fetch_addr[31:28]: 4'b0100 -> BIOS, 4'b0001 -> IMEM, else none.
  - The selected port gets en = ctrl_imem_en || rst and the word address fetch_addr[AW+1:2]; the other port gets en = 0.
- Update when ctrl_pc_en = 1: pc_q <= pc_next; src_q <= selected source.
- Stall (ctrl_pc_en = 0):
  - pc_q and src_q hold.
  - RAM enable is low, so RAM output holds; if_inst/if_pc stay stable.
- Data path:
  - if_inst = src_q==01 ? bios_dout : src_q==10 ? imem_dout : NOP_INST.
  - if_pc = pc_q.
- Redirect:
  - In the cycle ctrl_pc_src = 1, the word currently on if_inst is wrong-path, so if_valid = 0 and if_inst = NOP_INST that cycle.
  - The target word appears next cycle with if_valid = 1.
- Stall together with redirect: redirect wins.
  - The PC still loads the target; the hazard unit never asserts both.
  - A bench check must flag this if it occurs.
- Unmapped region (src_q = 00): if_valid = 0 and if_inst = NOP_INST. No exception is raised.
- Latency: one cycle from PC update to instruction valid. Sustained throughput is 1 inst/cycle with no stalls.

Decomposition:
- Shared package/header (alongside Opcode.vh), `define constants:
  - RESET_PC, NOP_INST
  - region codes BIOS_REGION = 4'b0100, IMEM_REGION = 4'b0001
  - src_q encodings
- PC register built from the existing REGISTER primitive with reset value and enable.
- One sub-module, fetch_region_decode (combinational: address -> source select and word addresses). It is reused later by the data-memory address decode.

Test Plan:
- Reset release: rst high 3 cycles, then low -> BOOT cycle: if_pc = 32'h4000_0000, if_valid = 1, if_inst = BIOS word 0. Next cycle if_pc = 32'h4000_0004.
- Straight-line run: no stalls or redirects for 8 cycles -> if_pc increments by 4 every cycle, if_inst matches BIOS model, if_valid = 1 throughout.
- Stall: ctrl_pc_en = 0, ctrl_imem_en = 0 for 2 cycles at pc 32'h4000_0010 -> if_pc and if_inst held for 3 total cycles, bios_en = 0. Resumes at 32'h4000_0014.
- Redirect to IMEM: ctrl_pc_src = 1, pc_target = 32'h1000_0020 -> that cycle if_valid = 0, if_inst = 32'h0000_0013. Next cycle if_pc = 32'h1000_0020 with IMEM word 8, imem_en = 1, bios_en = 0.
- Misaligned/unmapped target: pc_target = 32'h1000_0023 -> fetch at 32'h1000_0020. Separately pc_target = 32'h2000_0000 -> if_valid = 0, NOP_INST, both enables 0.
- Reset mid-stall: assert rst while ctrl_pc_en = 0 -> next cycle pc_q = RESET_PC, if_valid = 0, then BOOT sequence repeats exactly.
